sic_issue_dispatch: RTL and testbench
=====================================

Name: sic_issue_dispatch

Overview:
- In-order issue stage directly upstream of the SIC execute units (ALU/branch SICs).
- Buffers decoded instructions in a small FIFO and stamps each with a monotonically increasing issue_id.
- Allocates ECR slots to branches and attaches the youngest unresolved branch's ECR as each instruction's dependency.
- Hands one packet per cycle to a requesting SIC, chosen by round-robin over sic_req_instr.

Parameters:
- NUM_SIC, 4, number of SIC execute units served.
- ID_WIDTH, 8, issue_id width; wraps modulo 2^ID_WIDTH.
- INFO_W, 64, width of the opaque decoded-instruction info field.
- FIFO_DEPTH, 4, input buffer entries (power of two, ≥2).
- NUM_ECR, 2, ECR slots; ECR id width EW = $clog2(NUM_ECR).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready.
- in_info  in  INFO_W  decoded info, passed through unchanged.
- in_is_branch  in  1  instruction writes an ECR (BEQ class).
- in_pred_taken  in  1  front-end prediction.
- sic_req_instr  in  NUM_SIC  per-SIC "idle, send me a packet".
- out_valid  out  NUM_SIC  one-hot packet strobe, one cycle per packet.
- out_info  out  INFO_W  packet info.
- out_issue_id  out  ID_WIDTH  packet issue_id.
- out_pred_taken  out  1  packet prediction.
- out_dep_ecr  out  1+EW  {valid,id}: ECR the packet must wait on.
- out_set_ecr  out  1+EW  {valid,id}: ECR the packet writes (branches only).
- ecr_release  in  NUM_ECR  per-slot pulse from retire logic: slot resolved and free.
- flush  in  1  mispredict flush pulse.

Behaviour:
- Reset: FIFO empty, in_ready=1, all out_* = 0, issue counter=0, all ECR slots free, last_ecr invalid, RR pointer=0.
- FIFO push: when in_valid && in_ready, the entry stores {info, is_branch, pred_taken}.
- in_ready = !full, computed from the registered count. No push while full, even if a pop occurs in the same cycle.
- Dispatch condition in cycle t: FIFO non-empty, flush=0, and eligible = sic_req_instr & ~out_valid is non-zero.
  - Masking with out_valid prevents double-sending to a SIC whose request lags by one cycle.
  - If the head is a branch, at least one ECR slot must be free; otherwise the head stalls. No reordering is allowed.
- Winner: the first eligible SIC at or after the RR pointer, wrapping. After a dispatch, the pointer moves to winner+1 mod NUM_SIC.
- Outputs are registered: the packet appears in cycle t+1 with out_valid[winner]=1 for exactly one cycle. out_valid = 0 in all other cycles.
- Field rules for a dispatched packet:
  - out_issue_id = counter; the counter increments by 1 per dispatch and wraps at 2^ID_WIDTH.
  - out_dep_ecr = last_ecr as sampled before this instruction's own allocation. An instruction never depends on itself.
  - Branch: allocate the lowest-numbered free slot s. Set out_set_ecr={1,s}, mark s busy, last_ecr <= {1,s}.
  - Non-branch: out_set_ecr = 0.
- ecr_release[k]:
  - Clears busy[k] at the clock edge.
  - If last_ecr.id==k, clears last_ecr.valid, unless a new allocation updates last_ecr in the same cycle; the allocation wins.
  - The freed slot becomes allocatable only from the next cycle, so allocation always sees pre-release busy bits.
- flush (priority over push, dispatch and release):
  - Empties the FIFO, frees all ECR slots, invalidates last_ecr, and forces out_valid=0 in the next cycle.
  - The issue counter and RR pointer are retained.
  - The in-flight out_valid packet already presented in the flush cycle is not retracted.
- Push and pop in the same cycle on a non-full FIFO: count is unchanged and ordering is preserved.
- Reset asserted mid-operation returns every state element to its reset value immediately (asynchronous).

Test Plan:
- Reset, push 3 non-branch instructions, sic_req_instr=4'b1111 held → out_valid 0001, 0010, 0100 on consecutive cycles; issue_ids 0, 1, 2; dep/set ECR all 0.
- Push branch B (pred_taken=1) then non-branch N → B: set_ecr={1,0}, dep_ecr=0. N: dep_ecr={1,0}, set_ecr=0.
- Push 3 branches, no releases → first two get set_ecr {1,0} and {1,1}. The third stalls and in_ready tracks FIFO fill. Pulse ecr_release[0] → third dispatches the cycle after the release edge with set_ecr={1,0} and dep_ecr={1,1}.
- Fill FIFO (4 entries) with sic_req_instr=0 → in_ready=0; a fifth in_valid is not accepted. Raise sic_req_instr[2] → one dispatch per request; the FIFO drains in order.
- Mid-stream flush with 3 entries buffered and ECR 0 busy → next cycle: FIFO empty, out_valid=0, both ECRs free. The next branch gets set_ecr={1,0} and dep_ecr=0, and its issue_id continues from the pre-flush counter.
- Issue 260 instructions with ID_WIDTH=8 → issue_id wraps 255→0. Assert rst_n=0 mid-dispatch → out_valid=0 and in_ready=1 asynchronously.

Source files
------------

// File: rtl/sic_issue_dispatch_if.sv
// Issue-stage bundle: decoded-instruction input, per-SIC packet output,
// ECR release and flush controls.
interface sic_issue_dispatch_if #(
  parameter int NUM_SIC  = 4,
  parameter int ID_WIDTH = 8,
  parameter int INFO_W   = 64,
  parameter int NUM_ECR  = 2
);
  localparam int EW = $clog2(NUM_ECR);

  logic                in_valid;
  logic                in_ready;
  logic [INFO_W-1:0]   in_info;
  logic                in_is_branch;
  logic                in_pred_taken;
  logic [NUM_SIC-1:0]  sic_req_instr;
  logic [NUM_SIC-1:0]  out_valid;
  logic [INFO_W-1:0]   out_info;
  logic [ID_WIDTH-1:0] out_issue_id;
  logic                out_pred_taken;
  logic [EW:0]         out_dep_ecr;
  logic [EW:0]         out_set_ecr;
  logic [NUM_ECR-1:0]  ecr_release;
  logic                flush;

  modport slave (
    input  in_valid, in_info, in_is_branch, in_pred_taken, sic_req_instr,
           ecr_release, flush,
    output in_ready, out_valid, out_info, out_issue_id, out_pred_taken,
           out_dep_ecr, out_set_ecr
  );

  modport master (
    output in_valid, in_info, in_is_branch, in_pred_taken, sic_req_instr,
           ecr_release, flush,
    input  in_ready, out_valid, out_info, out_issue_id, out_pred_taken,
           out_dep_ecr, out_set_ecr
  );
endinterface

// File: rtl/sic_issue_dispatch.sv
// In-order issue stage: buffers decoded instructions, stamps issue ids,
// allocates ECR slots to branches and dispatches round-robin to idle SICs.
module sic_issue_dispatch #(
  parameter int NUM_SIC    = 4,
  parameter int ID_WIDTH   = 8,
  parameter int INFO_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_ECR    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  sic_issue_dispatch_if.slave bus
);
  localparam int EW = $clog2(NUM_ECR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(NUM_SIC);

  logic [INFO_W-1:0]   fifo_info [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_br;
  logic [FIFO_DEPTH-1:0] fifo_pt;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                alloc;

  logic [INFO_W-1:0]   head_info;
  logic                head_br;
  logic                head_pt;

  logic [NUM_SIC-1:0]  eligible;
  logic [SW-1:0]       rr_ptr;
  logic [SW-1:0]       winner;
  logic [SW-1:0]       cand;
  logic                found;

  logic [NUM_ECR-1:0]  ecr_busy;
  logic [EW-1:0]       free_slot;
  logic                any_free;
  logic                last_vld;
  logic [EW-1:0]       last_id;

  logic [ID_WIDTH-1:0] issue_cnt;
  logic [NUM_SIC-1:0]  out_valid_q;
  logic [INFO_W-1:0]   out_info_q;
  logic [ID_WIDTH-1:0] out_id_q;
  logic                out_pt_q;
  logic [EW:0]         out_dep_q;
  logic [EW:0]         out_set_q;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign head_info = fifo_info[rd_ptr];
  assign head_br   = fifo_br[rd_ptr];
  assign head_pt   = fifo_pt[rd_ptr];

  // A SIC whose request is still high the cycle after it was served must
  // not receive a second packet.
  assign eligible = bus.sic_req_instr & ~out_valid_q;

  assign push  = bus.in_valid & ~full & ~bus.flush;
  assign pop   = ~empty & ~bus.flush & (|eligible) & (~head_br | any_free);
  assign alloc = pop & head_br;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      cand = SW'((int'(rr_ptr) + i) % NUM_SIC);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Lowest-numbered free slot; busy bits are the registered (pre-release) view.
  always_comb begin
    free_slot = '0;
    any_free  = 1'b0;
    for (int k = NUM_ECR - 1; k >= 0; k--) begin
      if (!ecr_busy[k]) begin
        free_slot = EW'(k);
        any_free  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_info[wr_ptr] <= bus.in_info;
      fifo_br[wr_ptr]   <= bus.in_is_branch;
      fifo_pt[wr_ptr]   <= bus.in_pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_info_q  <= '0;
      out_id_q    <= '0;
      out_pt_q    <= 1'b0;
      out_dep_q   <= '0;
      out_set_q   <= '0;
      issue_cnt   <= '0;
      rr_ptr      <= '0;
    end else begin
      out_valid_q <= '0;
      if (pop) begin
        out_valid_q <= NUM_SIC'(1) << winner;
        out_info_q  <= head_info;
        out_id_q    <= issue_cnt;
        out_pt_q    <= head_pt;
        out_dep_q   <= {last_vld, last_id};
        out_set_q   <= head_br ? {1'b1, free_slot} : '0;
        issue_cnt   <= issue_cnt + 1'b1;
        rr_ptr      <= (winner == SW'(NUM_SIC - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  // A same-cycle allocation overrides a release that targets last_ecr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecr_busy <= '0;
      last_vld <= 1'b0;
      last_id  <= '0;
    end else if (bus.flush) begin
      ecr_busy <= '0;
      last_vld <= 1'b0;
    end else begin
      ecr_busy <= (ecr_busy & ~bus.ecr_release)
                | (alloc ? (NUM_ECR'(1) << free_slot) : '0);
      if (alloc) begin
        last_vld <= 1'b1;
        last_id  <= free_slot;
      end else if (last_vld && bus.ecr_release[last_id]) begin
        last_vld <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = ~full;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_info       = out_info_q;
  assign bus.out_issue_id   = out_id_q;
  assign bus.out_pred_taken = out_pt_q;
  assign bus.out_dep_ecr    = out_dep_q;
  assign bus.out_set_ecr    = out_set_q;

endmodule

// File: tb/tb_sic_issue_dispatch.sv
// Bench for sic_issue_dispatch: vector tables feed a scoreboard queue that a
// negedge monitor drains; hand sequences cover stall, flush and reset timing.
module tb_sic_issue_dispatch;
  localparam int NUM_SIC    = 4;
  localparam int ID_WIDTH   = 8;
  localparam int INFO_W     = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_ECR    = 2;

  typedef struct {
    logic [INFO_W-1:0]   info;
    logic                br;
    logic                pt;
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          dep;
    logic [1:0]          set;
    logic [NUM_SIC-1:0]  ov;   // zero: winner not checked, only one-hot
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sic_issue_dispatch_if #(.NUM_SIC(NUM_SIC), .ID_WIDTH(ID_WIDTH),
                          .INFO_W(INFO_W), .NUM_ECR(NUM_ECR)) bus ();

  sic_issue_dispatch #(.NUM_SIC(NUM_SIC), .ID_WIDTH(ID_WIDTH), .INFO_W(INFO_W),
                       .FIFO_DEPTH(FIFO_DEPTH), .NUM_ECR(NUM_ECR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t sb[$];
  vec_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [INFO_W-1:0] info, input logic br, input logic pt,
                              input logic [ID_WIDTH-1:0] id, input logic [1:0] dep,
                              input logic [1:0] set, input logic [NUM_SIC-1:0] ov);
    vec_t v;
    v.info = info; v.br = br; v.pt = pt; v.id = id; v.dep = dep; v.set = set; v.ov = ov;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid != '0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pkt: out_valid=%b id=%0d while nothing expected",
                 bus.out_valid, bus.out_issue_id);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("pkt_fields id%0d", mon_e.id),
            {bus.out_info, bus.out_issue_id, bus.out_pred_taken, bus.out_dep_ecr, bus.out_set_ecr},
            {mon_e.info, mon_e.id, mon_e.pt, mon_e.dep, mon_e.set});
        if (mon_e.ov != '0)
          chk($sformatf("pkt_sic id%0d", mon_e.id), bus.out_valid, mon_e.ov);
        else
          chk($sformatf("pkt_onehot id%0d", mon_e.id), $onehot(bus.out_valid), 1);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_info = '0; bus.in_is_branch = 0; bus.in_pred_taken = 0;
    bus.sic_req_instr = '0; bus.ecr_release = '0; bus.flush = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_issue_id",  bus.out_issue_id, 0);
    chk("rst_dep_ecr",   bus.out_dep_ecr, 0);
    chk("rst_set_ecr",   bus.out_set_ecr, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input vec_t v, input bit exp_out);
    int guard;
    guard = 0;
    bus.in_valid = 1; bus.in_info = v.info; bus.in_is_branch = v.br; bus.in_pred_taken = v.pt;
    if (exp_out) sb.push_back(v);
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stuck at 0, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 600) begin
      @(posedge clk);
      guard++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  vec_t t1[5];
  vec_t t3[6];

  initial begin
    t1[0] = mk(64'hA000_0000_0000_0001, 0, 0, 8'd0, 2'b00, 2'b00, 4'b0001);
    t1[1] = mk(64'hA000_0000_0000_0002, 0, 1, 8'd1, 2'b00, 2'b00, 4'b0010);
    t1[2] = mk(64'hA000_0000_0000_0003, 0, 0, 8'd2, 2'b00, 2'b00, 4'b0100);
    t1[3] = mk(64'hB000_0000_0000_00B0, 1, 1, 8'd3, 2'b00, 2'b10, 4'b1000);
    t1[4] = mk(64'hC000_0000_0000_00C0, 0, 0, 8'd4, 2'b10, 2'b00, 4'b0001);

    t3[0] = mk(64'h0000_0000_0000_0B00, 1, 1, 8'd0, 2'b00, 2'b10, 4'b0001);
    t3[1] = mk(64'h0000_0000_0000_0B01, 1, 0, 8'd1, 2'b10, 2'b11, 4'b0010);
    t3[2] = mk(64'h0000_0000_0000_0B02, 1, 1, 8'd2, 2'b11, 2'b10, 4'b0100);
    t3[3] = mk(64'h0000_0000_0000_0E03, 0, 0, 8'd3, 2'b10, 2'b00, 4'b1000);
    t3[4] = mk(64'h0000_0000_0000_0E04, 0, 1, 8'd4, 2'b10, 2'b00, 4'b0001);
    t3[5] = mk(64'h0000_0000_0000_0E05, 0, 0, 8'd5, 2'b10, 2'b00, 4'b0010);

    // basic round-robin and branch dependency
    do_reset();
    bus.sic_req_instr = 4'b1111;
    for (int i = 0; i < 5; i++) push(t1[i], 1);
    bus.in_valid = 0;
    drain("t1");

    // ECR exhaustion stall, then release of slot 0
    do_reset();
    bus.sic_req_instr = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      push(t3[i], 1);
      chk($sformatf("t3_in_ready_%0d", i), bus.in_ready, (i == 5) ? 1'b0 : 1'b1);
    end
    bus.in_valid = 0;
    @(negedge clk);
    chk("t3_stalled", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.ecr_release = 2'b01;
    @(posedge clk);
    #1;
    bus.ecr_release = 2'b00;
    @(negedge clk);
    chk("t3_no_early_dispatch", bus.out_valid, 0);
    @(posedge clk);
    #1;
    chk("t3_after_release", bus.out_valid, 4'b0100);
    drain("t3");

    // full FIFO rejects a fifth entry; a single requester drains in order
    do_reset();
    for (int i = 0; i < 4; i++)
      push(mk(64'h4444_0000_0000_0000 + 64'(i), 0, i[0], 8'(i), 2'b00, 2'b00, 4'b0100), 1);
    chk("t4_full_in_ready", bus.in_ready, 0);
    bus.in_info = 64'hDEAD_DEAD_DEAD_DEAD;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t4_still_full", bus.in_ready, 0);
    bus.in_valid = 0;
    bus.sic_req_instr = 4'b0100;
    @(posedge clk);
    #1;
    chk("t4_first", bus.out_valid, 4'b0100);
    @(posedge clk);
    #1;
    chk("t4_masked", bus.out_valid, 4'b0000);
    @(posedge clk);
    #1;
    chk("t4_second", bus.out_valid, 4'b0100);
    drain("t4");

    // flush with three buffered entries and ECR 0 busy
    do_reset();
    push(mk(64'hF000_0000_0000_00F0, 1, 1, 8'd0, 2'b00, 2'b10, 4'b0001), 1);
    for (int i = 1; i < 4; i++)
      push(mk(64'hF100_0000_0000_0000 + 64'(i), 0, 0, 8'd0, 2'b00, 2'b00, 4'b0000), 0);
    bus.in_valid = 0;
    bus.sic_req_instr = 4'b0001;
    @(posedge clk);
    #1;
    bus.sic_req_instr = 4'b0000;
    bus.flush = 1;
    chk("t5_inflight_kept", bus.out_valid, 4'b0001);
    @(posedge clk);
    #1;
    bus.flush = 0;
    chk("t5_flush_out_valid", bus.out_valid, 0);
    chk("t5_flush_in_ready", bus.in_ready, 1);
    bus.sic_req_instr = 4'b1111;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_fifo_emptied", sb.size(), 0);
    push(mk(64'hF200_0000_0000_0001, 1, 0, 8'd1, 2'b00, 2'b10, 4'b0000), 1);
    push(mk(64'hF200_0000_0000_0002, 1, 1, 8'd2, 2'b10, 2'b11, 4'b0000), 1);
    bus.in_valid = 0;
    drain("t5");

    // issue id wrap, then asynchronous reset mid-dispatch
    do_reset();
    bus.sic_req_instr = 4'b1111;
    for (int i = 0; i < 260; i++)
      push(mk({32'h5A5A_0000, 32'(i)}, 0, i[1], 8'(i), 2'b00, 2'b00, 4'b0000), 1);
    bus.in_valid = 0;
    drain("t6_wrap");
    bus.sic_req_instr = 4'b0000;
    for (int i = 0; i < 4; i++)
      push(mk({32'h6B6B_0000, 32'(i)}, 0, 0, 8'(4 + i), 2'b00, 2'b00, 4'b0000), 1);
    bus.in_valid = 0;
    bus.sic_req_instr = 4'b1111;
    @(posedge clk);
    #1;
    chk("t6_presented", |bus.out_valid, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", bus.out_valid, 0);
    chk("t6_async_in_ready", bus.in_ready, 1);
    chk("t6_async_issue_id", bus.out_issue_id, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_idle_after_reset", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
